// File: rtl/mips_sys_pkg.sv
// Address map and timer control-bit layout of the MIPS data-port responder,
// plus the address decoder shared by the top-level read and write paths.
package mips_sys_pkg;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] RAM_LIMIT   = 32'h0000_1FFF;
  localparam logic [31:0] ADDR_LED    = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_SW     = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_TCOUNT = 32'hFFFF_0010;
  localparam logic [31:0] ADDR_TCMP   = 32'hFFFF_0014;
  localparam logic [31:0] ADDR_TCTRL  = 32'hFFFF_0018;

  localparam int TCTRL_EN      = 0;
  localparam int TCTRL_AUTOCLR = 1;
  localparam int TCTRL_FLAG    = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_TCOUNT,
    SEL_TCMP,
    SEL_TCTRL
  } sel_e;

  // Takes the word address (bits [31:2]); RAM_BASE is zero, so only the limit matters.
  function automatic sel_e decode(input logic [29:0] word);
    sel_e sel;
    sel = SEL_NONE;
    if (word <= RAM_LIMIT[31:2])             sel = SEL_RAM;
    else if (word == ADDR_LED[31:2])         sel = SEL_LED;
    else if (word == ADDR_SW[31:2])          sel = SEL_SW;
    else if (word == ADDR_TCOUNT[31:2])      sel = SEL_TCOUNT;
    else if (word == ADDR_TCMP[31:2])        sel = SEL_TCMP;
    else if (word == ADDR_TCTRL[31:2])       sel = SEL_TCTRL;
    return sel;
  endfunction

endpackage

// File: rtl/mips_timer.sv
// Free-running compare timer: TCOUNT/TCMP/TCTRL with a sticky match flag
// that drives the interrupt line.
module mips_timer
  import mips_sys_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_tcount,
  input  logic        wr_tcmp,
  input  logic        wr_tctrl,
  input  logic [31:0] wdata,
  output logic [31:0] tcount,
  output logic [31:0] tcmp,
  output logic [31:0] tctrl,
  output logic        irq
);

  logic [31:0] tcount_reg, tcount_next;
  logic [31:0] tcmp_reg;
  logic        en_reg, autoclr_reg, flag_reg, flag_next;
  logic        match;

  // Match uses the EN value held before any TCTRL write lands this cycle.
  assign match = en_reg && (tcount_reg == tcmp_reg);

  always_comb begin
    tcount_next = tcount_reg;
    if (wr_tcount)
      tcount_next = wdata;
    else if (match && autoclr_reg)
      tcount_next = 32'h0;
    else if (en_reg)
      tcount_next = tcount_reg + 32'h1;
  end

  always_comb begin
    flag_next = flag_reg;
    if (match)
      flag_next = 1'b1;
    else if (wr_tctrl && wdata[TCTRL_FLAG])
      flag_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcount_reg  <= 32'h0;
      tcmp_reg    <= 32'hFFFF_FFFF;
      en_reg      <= 1'b0;
      autoclr_reg <= 1'b0;
      flag_reg    <= 1'b0;
    end else begin
      tcount_reg <= tcount_next;
      flag_reg   <= flag_next;
      if (wr_tcmp)
        tcmp_reg <= wdata;
      if (wr_tctrl) begin
        en_reg      <= wdata[TCTRL_EN];
        autoclr_reg <= wdata[TCTRL_AUTOCLR];
      end
    end
  end

  assign tcount = tcount_reg;
  assign tcmp   = tcmp_reg;
  assign tctrl  = {29'h0, flag_reg, autoclr_reg, en_reg};
  assign irq    = flag_reg;

endmodule

// File: rtl/mips_data_responder.sv
// Data-port responder for the MIPS core: word RAM, LED register, synchronized
// switches and the compare timer, all behind one combinational read mux.
module mips_data_responder
  import mips_sys_pkg::*;
#(
  parameter int RAM_WORDS      = 2048,
  parameter int SW_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  sel_e          sel;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram [RAM_WORDS];
  logic [15:0]   led_reg;
  logic [15:0]   sync_reg [SW_SYNC_STAGES];
  logic [31:0]   tcount, tcmp, tctrl;
  logic          unused_low_addr;

  assign unused_low_addr = &{1'b0, memaddr[1:0]};
  assign sel     = decode(memaddr[31:2]);
  assign ram_idx = memaddr[2 +: AW];

  // RAM is deliberately left out of reset so its contents survive it.
  always_ff @(posedge clk) begin
    if (memwrite && sel == SEL_RAM)
      ram[ram_idx] <= memwritedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      led_reg <= 16'h0;
    else if (memwrite && sel == SEL_LED)
      led_reg <= memwritedata[15:0];
  end

  generate
    for (genvar gi = 0; gi < SW_SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          sync_reg[gi] <= 16'h0;
        else if (gi == 0)
          sync_reg[gi] <= sw;
        else
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  mips_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_tcount (memwrite && sel == SEL_TCOUNT),
    .wr_tcmp   (memwrite && sel == SEL_TCMP),
    .wr_tctrl  (memwrite && sel == SEL_TCTRL),
    .wdata     (memwritedata),
    .tcount    (tcount),
    .tcmp      (tcmp),
    .tctrl     (tctrl),
    .irq       (timer_irq)
  );

  always_comb begin
    memreaddata = 32'h0;
    case (sel)
      SEL_RAM:    memreaddata = ram[ram_idx];
      SEL_LED:    memreaddata = {16'h0, led_reg};
      SEL_SW:     memreaddata = {16'h0, sync_reg[SW_SYNC_STAGES-1]};
      SEL_TCOUNT: memreaddata = tcount;
      SEL_TCMP:   memreaddata = tcmp;
      SEL_TCTRL:  memreaddata = tctrl;
      default:    memreaddata = 32'h0;
    endcase
  end

  assign led = led_reg;

endmodule

// File: doc/mips_data_responder.md
# mips_data_responder

Responder on the MIPS CPU data-memory port: accepts `memwrite`/`memaddr`/`memwritedata` from the core and returns `memreaddata`. It contains a 2048-word data RAM, a LED output register, a synchronized switch input, and a compare timer that raises an interrupt flag. It sits beside the CPU in the MIPS system top, in place of a bare data memory.

## Interface

Parameters:

- `RAM_WORDS`, 2048: number of data RAM words (power of two, ≤ 2048).
- `SW_SYNC_STAGES`, 2: synchronizer depth on `sw`.

Ports:

- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `memwrite` in 1: write strobe from the CPU, qualified by the rising edge of `clk`.
- `memaddr` in 32: byte address; bits [1:0] are ignored (word access only).
- `memwritedata` in 32: write data.
- `memreaddata` out 32: read data, combinational from `memaddr`.
- `sw` in 16: asynchronous board switches.
- `led` out 16: LED register value.
- `timer_irq` out 1: timer match flag, level.

## Operation

Address map (decode on full 32 bits, `[1:0]` masked):

- 0x0000_0000 to 0x0000_1FFF: RAM, index `memaddr[12:2]`. Not cleared by reset.
- 0xFFFF_0000 LED: R/W, bits [15:0]; reads return zero-extended value.
- 0xFFFF_0004 SW: read-only synchronized `sw`, zero-extended. Writes are ignored.
- 0xFFFF_0010 TCOUNT: R/W, 32-bit counter.
- 0xFFFF_0014 TCMP: R/W, 32-bit compare value.
- 0xFFFF_0018 TCTRL: bit0 EN (R/W), bit1 AUTOCLR (R/W), bit2 FLAG (read; write 1 clears, write 0 no effect). Other bits read 0.
- Any other address: reads 0, writes dropped.

Timer, evaluated each cycle:

- EN=1 and TCOUNT==TCMP:
  - set FLAG;
  - next TCOUNT = 0 if AUTOCLR, else TCOUNT+1 (mod 2^32, wraps 0xFFFF_FFFF to 0).
- EN=1, no match: TCOUNT+1 mod 2^32.
- EN=0: TCOUNT holds; no match detection.
- CPU write to TCOUNT in the same cycle as an increment or auto-clear: the written value wins.
- Match-set and write-1-to-clear of FLAG in the same cycle: set wins, so FLAG stays 1.
- Writing TCTRL updates EN/AUTOCLR. The match check in that cycle uses the old EN.
- `timer_irq` = FLAG.

Reset values:

- `led` = 0.
- TCOUNT = 0.
- TCMP = 0xFFFF_FFFF.
- TCTRL = 0 (so `timer_irq` = 0).
- Synchronizer stages = 0.
- `memreaddata` follows the decode of the current `memaddr`; reset registers read their reset values.

## Timing

- Reads: zero latency, combinational from `memaddr` and current register/RAM state.
- Writes: take effect at the rising edge where `memwrite`=1. The new value is visible on `memreaddata` in the following cycle. Read-during-write in the same cycle returns the old value.
- `sw` to SW register: `SW_SYNC_STAGES` cycles of latency.
- FLAG set: `timer_irq` rises one cycle after the cycle in which TCOUNT==TCMP with EN=1.
- Reset asserted mid-operation: all registers return to reset values immediately. RAM contents are retained but undefined after power-up.

## Structure

- Shared package `mips_sys_pkg`:
  - address constants `ADDR_LED`, `ADDR_SW`, `ADDR_TCOUNT`, `ADDR_TCMP`, `ADDR_TCTRL`, `RAM_BASE`, `RAM_LIMIT`;
  - TCTRL bit indices `TCTRL_EN`, `TCTRL_AUTOCLR`, `TCTRL_FLAG`.
- Sub-module `mips_timer`:
  - holds TCOUNT/TCMP/TCTRL, match logic, and write/clear priority;
  - interface: write strobes per register, write data, read outputs, `irq`.
- Top holds address decode, RAM array, LED register, switch synchronizer, and read mux.

## Test plan

- Write 0xDEADBEEF to 0x0000_0040, then read 0x0000_0040 → 0xDEADBEEF. Read 0x0000_0043 → 0xDEADBEEF (low bits ignored). Read 0x0000_2000 → 0.
- After reset: read LED → 0, TCMP → 0xFFFF_FFFF, TCTRL → 0, `timer_irq`=0. Write 0x0001_A5A5 to LED → `led`=0xA5A5, read → 0x0000_A5A5.
- Drive `sw`=0x1234 → SW reads old value for 2 cycles, then 0x0000_1234. Write to SW → no change.
- TCMP=5, TCTRL=0b011 from TCOUNT=0:
  - `timer_irq` rises the cycle after TCOUNT==5;
  - TCOUNT then reads 0, 1, …;
  - write TCTRL=0b111 → FLAG clears unless a match occurs that same cycle.
- TCOUNT=0xFFFF_FFFE, TCMP=3, EN=1, AUTOCLR=0 → reads 0xFFFF_FFFF, 0, 1, 2, 3, then FLAG set, counting continues at 4. Write TCOUNT=100 during counting → next read 100.
- Assert `reset` while EN=1, `led`≠0 and FLAG=1 → `led`, TCOUNT and `timer_irq` go to 0 without waiting for a clock edge. RAM word at 0x40 still reads 0xDEADBEEF.
